// File: rtl/dcache_mem_ctrl.sv
// Memory-side responder for the data cache block-miss interface: services one
// 16-byte refill or writeback at a time as a byte-serial sequence on an 8-bit RAM bus.
module dcache_mem_ctrl #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    readyIn,
  input  logic                    missIn,
  input  logic [31:BLOCK_WIDTH]   missAddrIn,
  input  logic                    readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
  input  logic [7:0]              ramDataIn,
  output logic [31:0]             ramAddrOut,
  output logic [7:0]              ramDataOut,
  output logic                    ramWriteOut,
  output logic                    memDataValid,
  output logic [31:BLOCK_WIDTH]   memAddr,
  output logic [BLOCK_SIZE*8-1:0] memDataOut,
  output logic                    acceptWrite,
  output logic                    busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                state;
  logic [31:BLOCK_WIDTH]     addr_q;
  logic                      rw_q;
  logic [BLOCK_SIZE*8-1:0]   wb_q;
  logic [BLOCK_WIDTH-1:0]    cnt;
  logic [BLOCK_WIDTH-1:0]    cap_idx;
  logic                      cap_valid;
  logic                      drain;

  assign ramAddrOut   = {addr_q, cnt};
  assign ramDataOut   = wb_q[{cnt, 3'b000} +: 8];
  assign ramWriteOut  = (state == WRITE) && readyIn;
  assign memDataValid = (state == DONE) && rw_q;
  assign acceptWrite  = (state == DONE) && !rw_q;
  assign busy         = (state == READ) || (state == WRITE);

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state      <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wb_q       <= '0;
      cnt        <= '0;
      cap_idx    <= '0;
      cap_valid  <= 1'b0;
      drain      <= 1'b0;
      memAddr    <= '0;
      memDataOut <= '0;
    end else begin
      // RAM data is only valid for the one cycle after issue, so capture ignores readyIn
      if (cap_valid)
        memDataOut[{cap_idx, 3'b000} +: 8] <= ramDataIn;
      cap_valid <= 1'b0;
      if (readyIn) begin
        case (state)
          IDLE: begin
            if (missIn) begin
              addr_q <= missAddrIn;
              rw_q   <= readWriteIn;
              if (!readWriteIn)
                wb_q <= writeBackIn;
              cnt    <= '0;
              state  <= readWriteIn ? READ : WRITE;
            end
          end
          READ: begin
            // drain is the extra cycle in which the last issued byte is captured
            if (drain) begin
              drain   <= 1'b0;
              memAddr <= addr_q;
              state   <= DONE;
            end else begin
              cap_valid <= 1'b1;
              cap_idx   <= cnt;
              cnt       <= cnt + 1'b1;
              if (cnt == '1)
                drain <= 1'b1;
            end
          end
          WRITE: begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              memAddr <= addr_q;
              state   <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
- Memory-side responder for the data cache's block-miss interface.
- Accepts one block request at a time: either a 16-byte block refill (read) or a dirty-block writeback (write).
- Performs the request as a byte-serial sequence on the single-port 8-bit RAM bus.
- Returns the assembled block with memDataValid, or signals writeback completion with acceptWrite.

Parameters:
- BLOCK_WIDTH, 4, log2 of block size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, block size in bytes (16).

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  reset; asynchronous, active-low.
- readyIn  input  1  global ready; low freezes the controller.
- missIn  input  1  cache request valid (level, held until serviced).
- missAddrIn  input  [31:BLOCK_WIDTH]  block address of the request.
- readWriteIn  input  1  request type: 1 = refill read, 0 = writeback.
- writeBackIn  input  BLOCK_SIZE*8  writeback block data; byte k = bits [8k+7:8k].
- ramDataIn  input  8  RAM read data; valid one cycle after its address is issued.
- ramAddrOut  output  32  RAM byte address.
- ramDataOut  output  8  RAM write data.
- ramWriteOut  output  1  RAM write enable.
- memDataValid  output  1  one-cycle pulse: refill block is on memDataOut.
- memAddr  output  [31:BLOCK_WIDTH]  block address of the completing transaction.
- memDataOut  output  BLOCK_SIZE*8  refilled block.
- acceptWrite  output  1  one-cycle pulse: writeback has completed.
- busy  output  1  a transaction is in progress.

Behaviour:
- Reset (resetIn low, asynchronous):
  - state = IDLE, all counters = 0.
  - Output reset values: ramAddrOut = 0, ramDataOut = 0, ramWriteOut = 0, memDataValid = 0, acceptWrite = 0, busy = 0, memAddr = 0, memDataOut = 0.
  - Asserting reset mid-transaction abandons the transaction; no completion pulse is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On missIn = 1, latch missAddrIn and readWriteIn.
  - If readWriteIn = 0, also latch writeBackIn.
  - busy = 1 from the next cycle.
  - Go to READ (readWriteIn = 1) or WRITE (readWriteIn = 0).
- READ:
  - Issue ramAddrOut = {addr, k} for k = 0..15, one per ready cycle, with ramWriteOut = 0.
  - The byte for address k is captured into memDataOut byte k in the following cycle.
  - The capture stage runs on every clock edge after an issue cycle, even when readyIn is low.
  - After byte 15 is captured (17 ready cycles after the first issue with no stalls), go to DONE.
- WRITE:
  - Per ready cycle k = 0..15: ramAddrOut = {addr, k}, ramDataOut = latched byte k, ramWriteOut = 1.
  - After byte 15, go to DONE.
- DONE (exactly one cycle):
  - memAddr = latched address.
  - For a read: memDataValid = 1 with memDataOut holding the full block.
  - For a write: acceptWrite = 1.
  - busy = 0, ramWriteOut = 0. Return to IDLE.
  - missIn is ignored in DONE; a new request is accepted no earlier than the cycle after DONE, so the cache's miss line has updated first.
- memAddr and memDataOut hold their value outside DONE; the cache ignores them when no pulse is present.
- readyIn low:
  - No state, counter or output register changes, except the read capture described above.
  - ramWriteOut is forced to 0 combinationally.
  - A write byte not committed in a stalled cycle is re-presented when readyIn returns.
  - Pulses are delayed, never dropped or duplicated.
- Request changes:
  - missIn or request fields changing mid-transaction are ignored; only the latched copy is used.
  - missIn deasserting mid-transaction does not abort.
- Address arithmetic: byte index k is a BLOCK_WIDTH-bit counter concatenated below the block address; no carry into the block address.
- Address 0x30000 and above (the IO region) is never requested by the cache; no special handling here.

Test Plan:
- Reset then idle: hold resetIn low, missIn = 0 -> all outputs 0, busy = 0; release reset -> outputs remain 0.
- Refill:
  - Stimulus: missIn = 1, readWriteIn = 1, missAddrIn = 0x0000010 (block 0x100); RAM model returns byte = low address byte.
  - Required: ramAddrOut steps 0x100..0x10F with ramWriteOut = 0.
  - Required: exactly one memDataValid pulse, with memAddr = 0x0000010 and memDataOut = 0x0F0E...0100.
- Writeback:
  - Stimulus: missIn = 1, readWriteIn = 0, missAddrIn = 0x0000020, writeBackIn = 0xFFEEDDCCBBAA99887766554433221100.
  - Required: writes 0x00 at 0x200 through 0xFF at 0x20F.
  - Required: one acceptWrite pulse with memAddr = 0x0000020; memDataValid stays 0.
- Stall: during a refill, drop readyIn for 3 cycles at byte 7 -> no ramWriteOut; final block still correct; pulse delayed by exactly 3 cycles.
- Back-to-back:
  - Stimulus: writeback at 0x0000030, then missIn held with a read of 0x0000030.
  - Required: read is accepted only in the cycle after acceptWrite; it returns the block just written.
- Reset mid-transaction: assert resetIn at byte 5 of a writeback -> ramWriteOut = 0 immediately, no acceptWrite pulse, state = IDLE after release.
